// File: rtl/l2_instruction_port.sv
// In-order instruction fetch port between the L1 I-cache L2 channel and a fixed-latency memory.
// Credit-gated issue keeps issued-but-unconsumed reads within the response FIFO capacity.
module l2_instruction_port #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int L2_BUS_WIDTH  = 32,
   parameter int QUEUE_DEPTH   = 4,
   parameter int MEM_LATENCY   = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       ADDRESS_TO_L2_VALID_INS,
   output logic                       ADDRESS_TO_L2_READY_INS,
   input  logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_INS,
   output logic                       DATA_FROM_L2_VALID_INS,
   input  logic                       DATA_FROM_L2_READY_INS,
   output logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_INS,
   output logic                       MEM_READ_EN,
   output logic [ADDRESS_WIDTH-3:0]   MEM_ADDRESS,
   input  logic [L2_BUS_WIDTH-1:0]    MEM_READ_DATA
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int WA = ADDRESS_WIDTH - 2;

   logic [WA-1:0]           req_mem [QUEUE_DEPTH];
   logic [PW-1:0]           req_wr_ptr, req_rd_ptr;
   logic [CW-1:0]           req_cnt;
   logic [L2_BUS_WIDTH-1:0] resp_mem [QUEUE_DEPTH];
   logic [PW-1:0]           resp_wr_ptr, resp_rd_ptr;
   logic [CW-1:0]           resp_cnt;
   logic [CW-1:0]           inflight_cnt;
   logic [MEM_LATENCY-1:0]  vpipe;
   logic [WA-1:0]           mem_addr_q;
   logic [CW:0]             credit_used;
   logic                    req_full, req_empty, resp_empty;
   logic                    push, issue, ret, pop;

   always_comb begin
      req_full    = (req_cnt == CW'(QUEUE_DEPTH));
      req_empty   = (req_cnt == '0);
      resp_empty  = (resp_cnt == '0);
      // Registered counts only: a response popped this cycle frees its credit next cycle.
      credit_used = {1'b0, inflight_cnt} + {1'b0, resp_cnt};
      issue       = !RST && !req_empty && (credit_used < (CW+1)'(QUEUE_DEPTH));
      push        = ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS;
      ret         = vpipe[MEM_LATENCY-1];
      pop         = DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS;
   end

   assign ADDRESS_TO_L2_READY_INS = !req_full && !RST;
   assign DATA_FROM_L2_VALID_INS  = !resp_empty;
   assign DATA_FROM_L2_INS        = resp_empty ? '0 : resp_mem[resp_rd_ptr];
   assign MEM_READ_EN             = issue;
   assign MEM_ADDRESS             = issue ? req_mem[req_rd_ptr] : mem_addr_q;

   always_ff @(posedge CLK) begin
      if (push) req_mem[req_wr_ptr] <= ADDRESS_TO_L2_INS;
      if (ret)  resp_mem[resp_wr_ptr] <= MEM_READ_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         req_wr_ptr <= '0;
         req_rd_ptr <= '0;
         req_cnt    <= '0;
         mem_addr_q <= '0;
      end else begin
         if (push)  req_wr_ptr <= req_wr_ptr + PW'(1);
         if (issue) begin
            req_rd_ptr <= req_rd_ptr + PW'(1);
            mem_addr_q <= req_mem[req_rd_ptr];
         end
         case ({push, issue})
            2'b10:   req_cnt <= req_cnt + CW'(1);
            2'b01:   req_cnt <= req_cnt - CW'(1);
            default: req_cnt <= req_cnt;
         endcase
      end
   end

   // Valid pipeline marks which memory cycles carry requested data; clearing it drops stale returns.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= issue;
         for (int unsigned i = 1; i < MEM_LATENCY; i++) vpipe[i] <= vpipe[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         inflight_cnt <= '0;
         resp_wr_ptr  <= '0;
         resp_rd_ptr  <= '0;
         resp_cnt     <= '0;
      end else begin
         case ({issue, ret})
            2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
            2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
            default: inflight_cnt <= inflight_cnt;
         endcase
         if (ret) resp_wr_ptr <= resp_wr_ptr + PW'(1);
         if (pop) resp_rd_ptr <= resp_rd_ptr + PW'(1);
         case ({ret, pop})
            2'b10:   resp_cnt <= resp_cnt + CW'(1);
            2'b01:   resp_cnt <= resp_cnt - CW'(1);
            default: resp_cnt <= resp_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_instruction_port.sv
// Bench for l2_instruction_port: vector table, scoreboarded sequences, and two extra
// parameter configurations checked for latency and ordering.
module tb_l2_instruction_port;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int QD  = 4;
   localparam int LAT = 2;
   localparam int WA  = AW - 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          a_valid, a_ready, d_valid, d_ready, m_en;
   logic [WA-1:0] a_addr, m_addr;
   logic [DW-1:0] d_data, m_data;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   l2_instruction_port #(.ADDRESS_WIDTH(AW), .L2_BUS_WIDTH(DW), .QUEUE_DEPTH(QD), .MEM_LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .ADDRESS_TO_L2_VALID_INS(a_valid), .ADDRESS_TO_L2_READY_INS(a_ready), .ADDRESS_TO_L2_INS(a_addr),
      .DATA_FROM_L2_VALID_INS(d_valid), .DATA_FROM_L2_READY_INS(d_ready), .DATA_FROM_L2_INS(d_data),
      .MEM_READ_EN(m_en), .MEM_ADDRESS(m_addr), .MEM_READ_DATA(m_data)
   );

   function automatic logic [DW-1:0] memf(input logic [WA-1:0] a);
      if (a == 30'h10) return 32'hDEADBEEF;
      return ({a, 2'b00} * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   // Memory returns data exactly LAT cycles after the read strobe; garbage otherwise.
   logic [DW-1:0] mpipe [LAT];
   always @(posedge CLK) begin
      mpipe[0] <= m_en ? memf(m_addr) : $urandom;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign m_data = mpipe[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [WA-1:0] exp_q[$];
   logic [WA-1:0] iss_q[$];
   int n_acc, n_iss, n_rsp, max_out;

   task automatic reset_counts();
      n_acc = 0; n_iss = 0; n_rsp = 0; max_out = 0;
   endtask

   // One clock cycle: drive just after the edge, observe mid-cycle against the scoreboard.
   task automatic step(input logic rst, input logic v, input logic [WA-1:0] a, input logic r);
      logic [WA-1:0] ea;
      @(posedge CLK); #1;
      RST = rst; a_valid = v; a_addr = a; d_ready = r;
      @(negedge CLK);
      if (m_en) begin
         n_iss++;
         if (iss_q.size() == 0) chk("issue_unexpected", 1'b1, 1'b0);
         else begin
            ea = iss_q.pop_front();
            chk("issue_addr", m_addr, ea);
         end
      end
      if (d_valid && d_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
         else begin
            ea = exp_q.pop_front();
            chk("rsp_data", d_data, memf(ea));
         end
      end
      if (a_valid && a_ready) begin
         exp_q.push_back(a_addr);
         iss_q.push_back(a_addr);
         n_acc++;
      end
      if (n_iss - n_rsp > max_out) max_out = n_iss - n_rsp;
   endtask

   typedef struct {
      logic          v;
      logic [WA-1:0] a;
      logic          r;
      logic          ar;
      logic          en;
      logic [WA-1:0] ma;
      logic          dv;
      logic [DW-1:0] d;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_rsp, last_rsp, ardy_drop;

      tbl[0] = '{1'b1, 30'h10, 1'b0, 1'b1, 1'b0, 30'h0,  1'b0, 32'h0};
      tbl[1] = '{1'b1, 30'h20, 1'b0, 1'b1, 1'b1, 30'h10, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b1, 30'h20, 1'b0, 32'h0};
      tbl[3] = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b0, 30'h20, 1'b0, 32'h0};
      tbl[4] = '{1'b0, 30'h0,  1'b0, 1'b1, 1'b0, 30'h20, 1'b1, 32'hDEADBEEF};
      tbl[5] = '{1'b0, 30'h0,  1'b1, 1'b1, 1'b0, 30'h20, 1'b1, 32'hDEADBEEF};
      tbl[6] = '{1'b0, 30'h0,  1'b1, 1'b1, 1'b0, 30'h20, 1'b1, memf(30'h20)};
      tbl[7] = '{1'b0, 30'h0,  1'b1, 1'b1, 1'b0, 30'h20, 1'b0, 32'h0};

      RST = 1'b1; a_valid = 1'b0; a_addr = '0; d_ready = 1'b0;
      reset_counts();
      step(1'b1, 1'b0, '0, 1'b0);
      chk("rst_ready_low", a_ready, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      chk("rst_ready_low2", a_ready, 1'b0);

      // Single/dual request timing; row 0 is the first cycle after reset.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, tbl[i].v, tbl[i].a, tbl[i].r);
         chk($sformatf("vec%0d_aready", i), a_ready, tbl[i].ar);
         chk($sformatf("vec%0d_mem_en", i), m_en, tbl[i].en);
         chk($sformatf("vec%0d_mem_addr", i), m_addr, tbl[i].ma);
         chk($sformatf("vec%0d_dvalid", i), d_valid, tbl[i].dv);
         chk($sformatf("vec%0d_data", i), d_data, tbl[i].d);
      end

      // Streaming: 16 back-to-back requests, consumer always ready.
      reset_counts();
      first_rsp = -1; last_rsp = -1; ardy_drop = 0;
      for (int c = 0; c < 30; c++) begin
         step(1'b0, c < 16, WA'(c), 1'b1);
         if (c < 16 && !a_ready) ardy_drop++;
         if (d_valid && d_ready) begin
            if (first_rsp < 0) first_rsp = c;
            last_rsp = c;
         end
      end
      chk("stream_first_cycle", first_rsp, 4);
      chk("stream_last_cycle", last_rsp, 19);
      chk("stream_count", n_rsp, 16);
      chk("stream_ready_drops", ardy_drop, 0);

      // Full backpressure: 10 requests offered with the consumer stalled.
      reset_counts();
      for (int c = 0; c < 20; c++) step(1'b0, n_acc < 10, WA'(32'h100 + n_acc), 1'b0);
      chk("bp_accepted", n_acc, 8);
      chk("bp_issues", n_iss, 4);
      chk("bp_ready_low", a_ready, 1'b0);
      chk("bp_no_response", n_rsp, 0);
      for (int c = 0; c < 80 && n_rsp < 10; c++) step(1'b0, n_acc < 10, WA'(32'h100 + n_acc), 1'b1);
      chk("bp_returned", n_rsp, 10);
      chk("bp_credit_bound", max_out <= QD, 1'b1);

      // Randomized traffic with simultaneous pop/return/issue.
      reset_counts();
      for (int c = 0; c < 100; c++)
         step(1'b0, ($urandom % 2) == 1, WA'($urandom), ($urandom % 3) != 0);
      for (int c = 0; c < 100 && n_rsp < n_acc; c++) step(1'b0, 1'b0, '0, 1'b1);
      chk("rnd_all_returned", n_rsp, n_acc);
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_credit_bound", max_out <= QD, 1'b1);

      // Reset one cycle after three issues.
      reset_counts();
      step(1'b0, 1'b1, 30'h30, 1'b0);
      step(1'b0, 1'b1, 30'h31, 1'b0);
      step(1'b0, 1'b1, 30'h32, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("mid_issues", n_iss, 3);
      step(1'b1, 1'b0, '0, 1'b0);
      chk("mid_rst_ready_low", a_ready, 1'b0);
      exp_q.delete();
      iss_q.delete();
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         chk($sformatf("mid_post%0d_dvalid", c), d_valid, 1'b0);
         chk($sformatf("mid_post%0d_data", c), d_data, 32'h0);
         chk($sformatf("mid_post%0d_mem_en", c), m_en, 1'b0);
         chk($sformatf("mid_post%0d_mem_addr", c), m_addr, 30'h0);
         chk($sformatf("mid_post%0d_ready", c), a_ready, 1'b1);
      end
      reset_counts();
      first_rsp = -1;
      step(1'b0, 1'b1, 30'h77, 1'b1);
      for (int c = 1; c < 12; c++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         if (d_valid && first_rsp < 0) first_rsp = c;
      end
      chk("mid_new_latency", first_rsp, 4);
      chk("mid_new_count", n_rsp, 1);

      for (int i = 0; i < 3000 && !(sweep[0].s_done && sweep[1].s_done); i++) @(posedge CLK);
      chk("sweep0_done", sweep[0].s_done, 1'b1);
      chk("sweep1_done", sweep[1].s_done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Extra configurations: (latency 1, depth 2) and (latency 5, depth 8).
   for (genvar g = 0; g < 2; g++) begin : sweep
      localparam int SL = (g == 0) ? 1 : 5;
      localparam int SQ = (g == 0) ? 2 : 8;
      logic          s_rst, s_av, s_ar, s_dv, s_dr, s_en;
      logic [WA-1:0] s_aa, s_ma;
      logic [DW-1:0] s_dd, s_md;
      logic [DW-1:0] s_pipe [SL];
      bit            s_done = 1'b0;

      l2_instruction_port #(.ADDRESS_WIDTH(AW), .L2_BUS_WIDTH(DW), .QUEUE_DEPTH(SQ), .MEM_LATENCY(SL)) u_dut (
         .CLK(CLK), .RST(s_rst),
         .ADDRESS_TO_L2_VALID_INS(s_av), .ADDRESS_TO_L2_READY_INS(s_ar), .ADDRESS_TO_L2_INS(s_aa),
         .DATA_FROM_L2_VALID_INS(s_dv), .DATA_FROM_L2_READY_INS(s_dr), .DATA_FROM_L2_INS(s_dd),
         .MEM_READ_EN(s_en), .MEM_ADDRESS(s_ma), .MEM_READ_DATA(s_md)
      );

      always @(posedge CLK) begin
         s_pipe[0] <= s_en ? memf(s_ma) : $urandom;
         for (int i = 1; i < SL; i++) s_pipe[i] <= s_pipe[i-1];
      end
      assign s_md = s_pipe[SL-1];

      initial begin
         logic [WA-1:0] q[$];
         logic [WA-1:0] ea;
         int first, sn_acc, sn_rsp;
         s_rst = 1'b1; s_av = 1'b0; s_aa = '0; s_dr = 1'b0;
         repeat (2) begin @(posedge CLK); #1; end
         s_rst = 1'b0; s_av = 1'b1; s_aa = 30'h7; s_dr = 1'b1;
         first = -1;
         for (int c = 0; c < 20 && first < 0; c++) begin
            if (c > 0) begin @(posedge CLK); #1; s_av = 1'b0; end
            @(negedge CLK);
            if (s_dv) begin
               first = c;
               checks++;
               if (s_dd !== memf(30'h7)) begin
                  errors++;
                  $display("FAIL sweep%0d_first_data: got %0h expected %0h", g, s_dd, memf(30'h7));
               end
            end
         end
         checks++;
         if (first != 2 + SL) begin
            errors++;
            $display("FAIL sweep%0d_latency: got %0d expected %0d", g, first, 2 + SL);
         end
         sn_acc = 0; sn_rsp = 0;
         for (int c = 0; c < 400 && sn_rsp < 24; c++) begin
            @(posedge CLK); #1;
            s_av = (sn_acc < 24) && (($urandom % 4) != 0);
            s_aa = WA'(32'h200 + sn_acc);
            s_dr = ($urandom % 4) != 0;
            @(negedge CLK);
            if (s_dv && s_dr) begin
               sn_rsp++;
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL sweep%0d_unexpected: got %0h expected none", g, s_dd);
               end else begin
                  ea = q.pop_front();
                  if (s_dd !== memf(ea)) begin
                     errors++;
                     $display("FAIL sweep%0d_order: got %0h expected %0h", g, s_dd, memf(ea));
                  end
               end
            end
            if (s_av && s_ar) begin
               q.push_back(s_aa);
               sn_acc++;
            end
         end
         checks++;
         if (sn_rsp != 24) begin
            errors++;
            $display("FAIL sweep%0d_count: got %0d expected 24", g, sn_rsp);
         end
         s_done = 1'b1;
      end
   end

endmodule
